uart_cmd_rx: RTL and testbench



---
 rtl/uart_cmd_rx.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver (16x oversampling) with an ASCII command decoder that
// selects the display/stream channel and switches UART streaming on or off.
module uart_cmd_rx #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int DVSR     = 212,
  parameter int DVSR_BIT = 9,
  parameter int NUM_CH   = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [3:0] channel_sel,
  output logic       stream_en,
  output logic       cmd_valid,
  output logic       cmd_err
);

  localparam int NBIT_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [7:0] ASCII_C  = 8'h43;
  localparam logic [7:0] ASCII_D  = 8'h44;
  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_D1, P_D2, P_CRC, P_CRE, P_CRD} p_state_t;

  // Two-flop synchronizer; idles high so reset cannot fake a start bit.
  logic rx_meta, rxs;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  logic [DVSR_BIT-1:0] baud_cnt;
  logic                tick;

  assign tick = (baud_cnt == DVSR_BIT'(DVSR - 1));

  always_ff @(posedge clk) begin
    if (rst)       baud_cnt <= '0;
    else if (tick) baud_cnt <= '0;
    else           baud_cnt <= baud_cnt + DVSR_BIT'(1);
  end

  rx_state_t         rx_state, rx_state_nx;
  logic [3:0]        s_reg, s_nx;
  logic [NBIT_W-1:0] n_reg, n_nx;
  logic [7:0]        b_reg, b_nx;
  logic              done_nx, ferr_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state  <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_state  <= rx_state_nx;
      s_reg     <= s_nx;
      n_reg     <= n_nx;
      b_reg     <= b_nx;
      rx_valid  <= done_nx;
      frame_err <= ferr_nx;
      if (done_nx) rx_data <= b_reg;
    end
  end

  // NOTE: every always_comb output gets a default first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    rx_state_nx = rx_state;
    s_nx        = s_reg;
    n_nx        = n_reg;
    b_nx        = b_reg;
    done_nx     = 1'b0;
    ferr_nx     = 1'b0;
    unique case (rx_state)
      IDLE: begin
        if (!rxs) begin
          rx_state_nx = START;
          s_nx        = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_reg == 4'd7) begin
            s_nx = '0;
            if (!rxs) begin
              rx_state_nx = DATA;
              n_nx        = '0;
            end else begin
              rx_state_nx = IDLE;
            end
          end else begin
            s_nx = s_reg + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_reg == 4'd15) begin
            s_nx = '0;
            b_nx = {rxs, b_reg[7:1]};
            if (n_reg == NBIT_W'(DBIT - 1)) rx_state_nx = STOP;
            else                            n_nx = n_reg + NBIT_W'(1);
          end else begin
            s_nx = s_reg + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_reg == 4'(SB_TICK - 1)) begin
            rx_state_nx = IDLE;
            if (rxs) done_nx = 1'b1;
            else     ferr_nx = 1'b1;
          end else begin
            s_nx = s_reg + 4'd1;
          end
        end
      end
      default: rx_state_nx = IDLE;
    endcase
  end

  p_state_t   p_state, p_nx;
  logic [3:0] d1, d0, d1_nx, d0_nx, ch_nx;
  logic       stream_nx, cv_nx, ce_nx, is_digit;
  logic [6:0] val;

  assign is_digit = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
  // d1*10 + d0 built from shifts so no multiplier is needed.
  assign val = ({3'b000, d1} << 3) + ({3'b000, d1} << 1) + {3'b000, d0};

  always_ff @(posedge clk) begin
    if (rst) begin
      p_state     <= P_IDLE;
      d1          <= '0;
      d0          <= '0;
      channel_sel <= '0;
      stream_en   <= 1'b1;
      cmd_valid   <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      p_state     <= p_nx;
      d1          <= d1_nx;
      d0          <= d0_nx;
      channel_sel <= ch_nx;
      stream_en   <= stream_nx;
      cmd_valid   <= cv_nx;
      cmd_err     <= ce_nx;
    end
  end

  always_comb begin
    p_nx      = p_state;
    d1_nx     = d1;
    d0_nx     = d0;
    ch_nx     = channel_sel;
    stream_nx = stream_en;
    cv_nx     = 1'b0;
    ce_nx     = 1'b0;
    if (frame_err) begin
      p_nx  = P_IDLE;
      ce_nx = 1'b1;
    end else if (rx_valid) begin
      p_nx = P_IDLE;
      unique case (p_state)
        P_IDLE: begin
          if      (rx_data == ASCII_C) p_nx = P_D1;
          else if (rx_data == ASCII_E) p_nx = P_CRE;
          else if (rx_data == ASCII_D) p_nx = P_CRD;
          else if (rx_data != ASCII_CR && rx_data != ASCII_LF) ce_nx = 1'b1;
        end
        P_D1: begin
          if (is_digit) begin
            d1_nx = rx_data[3:0];
            p_nx  = P_D2;
          end else begin
            ce_nx = 1'b1;
          end
        end
        P_D2: begin
          if (is_digit) begin
            d0_nx = rx_data[3:0];
            p_nx  = P_CRC;
          end else begin
            ce_nx = 1'b1;
          end
        end
        P_CRC: begin
          if (rx_data == ASCII_CR && val <= 7'(NUM_CH - 1)) begin
            ch_nx = val[3:0];
            cv_nx = 1'b1;
          end else begin
            ce_nx = 1'b1;
          end
        end
        P_CRE, P_CRD: begin
          if (rx_data == ASCII_CR) begin
            stream_nx = (p_state == P_CRE);
            cv_nx     = 1'b1;
          end else begin
            ce_nx = 1'b1;
          end
        end
        default: p_nx = P_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: drives 8N1 frames at DVSR=4 (64 clk/bit)
// and checks received bytes, command effects and error pulses.
module tb_uart_cmd_rx;

  localparam int DVSR     = 4;
  localparam int BIT_CLKS = 16 * DVSR;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, stream_en, cmd_valid, cmd_err;
  logic [3:0] channel_sel;

  int passed = 0;
  int total  = 0;

  int n_valid = 0, n_ferr = 0, n_cv = 0, n_ce = 0;
  int n_both_rx = 0, n_both_cmd = 0;

  uart_cmd_rx #(.DVSR(DVSR)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .channel_sel(channel_sel),
    .stream_en  (stream_en),
    .cmd_valid  (cmd_valid),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (rx_valid)               n_valid    <= n_valid + 1;
    if (frame_err)              n_ferr     <= n_ferr + 1;
    if (cmd_valid)              n_cv       <= n_cv + 1;
    if (cmd_err)                n_ce       <= n_ce + 1;
    if (rx_valid && frame_err)  n_both_rx  <= n_both_rx + 1;
    if (cmd_valid && cmd_err)   n_both_cmd <= n_both_cmd + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic send_bit(input logic v, input int clks);
    rx = v;
    repeat (clks) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) send_bit(b[i], BIT_CLKS);
    if (stop_ok) begin
      send_bit(1'b1, BIT_CLKS);
    end else begin
      // Low across the stop-bit sampling point, then back to idle long enough
      // for the trailing low to be rejected as a false start.
      send_bit(1'b0, 44);
      send_bit(1'b1, 2 * BIT_CLKS);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic gap();
    repeat (8) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else passed++; total++;
    if ({rx_valid, frame_err, cmd_valid, cmd_err} !== 4'b0000)
      $display("FAIL reset_pulses: got %b want 0000", {rx_valid, frame_err, cmd_valid, cmd_err}); else passed++; total++;
    if (channel_sel !== 4'd0) $display("FAIL reset_channel: got %0d want 0", channel_sel); else passed++; total++;
    if (stream_en !== 1'b1) $display("FAIL reset_stream_en: got %b want 1", stream_en); else passed++; total++;
    @(posedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  task automatic test_single_byte();
    int v0 = n_valid, f0 = n_ferr;
    send_byte(8'hA5, 1'b1);
    gap();
    if (n_valid - v0 !== 1) $display("FAIL byte_rx_valid_count: got %0d want 1", n_valid - v0); else passed++; total++;
    if (rx_data !== 8'hA5) $display("FAIL byte_rx_data: got %h want a5", rx_data); else passed++; total++;
    if (n_ferr - f0 !== 0) $display("FAIL byte_frame_err: got %0d want 0", n_ferr - f0); else passed++; total++;
    if (stream_en !== 1'b1) $display("FAIL byte_stream_en: got %b want 1", stream_en); else passed++; total++;
    if (channel_sel !== 4'd0) $display("FAIL byte_channel: got %0d want 0", channel_sel); else passed++; total++;
  endtask

  task automatic test_channel();
    int c0 = n_cv, e0 = n_ce;
    send_str("C07\r"); gap();
    if (n_cv - c0 !== 1) $display("FAIL c07_cmd_valid: got %0d want 1", n_cv - c0); else passed++; total++;
    if (n_ce - e0 !== 0) $display("FAIL c07_cmd_err: got %0d want 0", n_ce - e0); else passed++; total++;
    if (channel_sel !== 4'd7) $display("FAIL c07_channel: got %0d want 7", channel_sel); else passed++; total++;
    send_str("C12\r"); gap();
    if (channel_sel !== 4'd12) $display("FAIL c12_channel: got %0d want 12", channel_sel); else passed++; total++;
    c0 = n_cv; e0 = n_ce;
    send_str("C13\r"); gap();
    if (n_ce - e0 !== 1) $display("FAIL c13_cmd_err: got %0d want 1", n_ce - e0); else passed++; total++;
    if (n_cv - c0 !== 0) $display("FAIL c13_cmd_valid: got %0d want 0", n_cv - c0); else passed++; total++;
    if (channel_sel !== 4'd12) $display("FAIL c13_channel: got %0d want 12", channel_sel); else passed++; total++;
  endtask

  task automatic test_stream();
    int c0 = n_cv, e0;
    send_str("D\r"); gap();
    if (stream_en !== 1'b0) $display("FAIL d_stream_en: got %b want 0", stream_en); else passed++; total++;
    if (n_cv - c0 !== 1) $display("FAIL d_cmd_valid: got %0d want 1", n_cv - c0); else passed++; total++;
    send_str("E\r"); gap();
    if (stream_en !== 1'b1) $display("FAIL e_stream_en: got %b want 1", stream_en); else passed++; total++;
    c0 = n_cv; e0 = n_ce;
    send_str("x"); gap();
    if (n_ce - e0 !== 1) $display("FAIL x_cmd_err: got %0d want 1", n_ce - e0); else passed++; total++;
    if (n_cv - c0 !== 0) $display("FAIL x_cmd_valid: got %0d want 0", n_cv - c0); else passed++; total++;
    if ({stream_en, channel_sel} !== {1'b1, 4'd12})
      $display("FAIL x_state: got %b/%0d want 1/12", stream_en, channel_sel); else passed++; total++;
  endtask

  task automatic test_frame_err();
    int v0 = n_valid, f0 = n_ferr, e0 = n_ce, c0;
    send_byte(8'h43, 1'b0);
    gap();
    if (n_ferr - f0 !== 1) $display("FAIL ferr_frame_err: got %0d want 1", n_ferr - f0); else passed++; total++;
    if (n_ce - e0 !== 1) $display("FAIL ferr_cmd_err: got %0d want 1", n_ce - e0); else passed++; total++;
    if (n_valid - v0 !== 0) $display("FAIL ferr_rx_valid: got %0d want 0", n_valid - v0); else passed++; total++;
    c0 = n_cv;
    send_str("C03\r"); gap();
    if (channel_sel !== 4'd3) $display("FAIL c03_channel: got %0d want 3", channel_sel); else passed++; total++;
    if (n_cv - c0 !== 1) $display("FAIL c03_cmd_valid: got %0d want 1", n_cv - c0); else passed++; total++;
  endtask

  task automatic test_glitch();
    int v0 = n_valid, f0 = n_ferr;
    @(posedge clk);
    rx = 1'b0;
    repeat (2) @(posedge clk);
    rx = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    if (n_valid - v0 !== 0) $display("FAIL glitch_rx_valid: got %0d want 0", n_valid - v0); else passed++; total++;
    if (n_ferr - f0 !== 0) $display("FAIL glitch_frame_err: got %0d want 0", n_ferr - f0); else passed++; total++;
  endtask

  task automatic test_back_to_back();
    int v0 = n_valid, c0 = n_cv;
    send_str("C05\r"); gap();
    if (n_valid - v0 !== 4) $display("FAIL b2b_rx_valid: got %0d want 4", n_valid - v0); else passed++; total++;
    if (n_cv - c0 !== 1) $display("FAIL b2b_cmd_valid: got %0d want 1", n_cv - c0); else passed++; total++;
    if (channel_sel !== 4'd5) $display("FAIL b2b_channel: got %0d want 5", channel_sel); else passed++; total++;
  endtask

  task automatic test_reset_mid_command();
    int v0, f0, c0, e0;
    send_str("D\r"); gap();
    if (stream_en !== 1'b0) $display("FAIL pre_rst_stream_en: got %b want 0", stream_en); else passed++; total++;
    send_str("C"); gap();
    v0 = n_valid; f0 = n_ferr;
    fork
      send_byte(8'h30, 1'b1);
      begin
        repeat (3 * BIT_CLKS) @(posedge clk);
        rst = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    @(negedge clk);
    if (n_valid - v0 !== 0 || n_ferr - f0 !== 0)
      $display("FAIL rst_abort_pulses: got %0d/%0d want 0/0", n_valid - v0, n_ferr - f0); else passed++; total++;
    if ({rx_data, channel_sel, stream_en} !== {8'h00, 4'd0, 1'b1})
      $display("FAIL rst_mid_state: got %h/%0d/%b want 00/0/1", rx_data, channel_sel, stream_en); else passed++; total++;
    @(posedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    c0 = n_cv; e0 = n_ce;
    send_str("0"); gap();
    if (n_ce - e0 !== 1) $display("FAIL rst_0_cmd_err: got %0d want 1", n_ce - e0); else passed++; total++;
    send_str("9\r"); gap();
    if (n_cv - c0 !== 0) $display("FAIL rst_tail_cmd_valid: got %0d want 0", n_cv - c0); else passed++; total++;
    if (channel_sel !== 4'd0) $display("FAIL rst_tail_channel: got %0d want 0", channel_sel); else passed++; total++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_channel();
    test_stream();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_command();
    if (n_both_rx !== 0) $display("FAIL rx_valid_and_frame_err: got %0d want 0", n_both_rx); else passed++; total++;
    if (n_both_cmd !== 0) $display("FAIL cmd_valid_and_cmd_err: got %0d want 0", n_both_cmd); else passed++; total++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
